// File: rtl/efi_arbiter_if.sv
// EFI arbiter bus bundle: per-requester argument/result streams (flattened,
// requester i at slice i) plus the single shared EFI unit stream pair.
// slave  = arbiter view, master = environment (requesters + EFI unit) view.
interface efi_arbiter_if #(
  parameter int N_REQUESTERS = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int DEST_WIDTH   = 8,
  parameter int USER_WIDTH   = 1
);
  logic [N_REQUESTERS*DATA_WIDTH-1:0] req_args_data;
  logic [N_REQUESTERS*DEST_WIDTH-1:0] req_args_dest;
  logic [N_REQUESTERS*USER_WIDTH-1:0] req_args_user;
  logic [N_REQUESTERS-1:0]            req_args_last;
  logic [N_REQUESTERS-1:0]            req_args_valid;
  logic [N_REQUESTERS-1:0]            req_args_ready;

  logic [DATA_WIDTH-1:0]              req_res_data;
  logic [DEST_WIDTH-1:0]              req_res_dest;
  logic [USER_WIDTH-1:0]              req_res_user;
  logic                               req_res_last;
  logic [N_REQUESTERS-1:0]            req_res_valid;
  logic [N_REQUESTERS-1:0]            req_res_ready;

  logic [DATA_WIDTH-1:0]              efi_args_data;
  logic [DEST_WIDTH-1:0]              efi_args_dest;
  logic [USER_WIDTH-1:0]              efi_args_user;
  logic                               efi_args_last;
  logic                               efi_args_valid;
  logic                               efi_args_ready;

  logic [DATA_WIDTH-1:0]              efi_res_data;
  logic [DEST_WIDTH-1:0]              efi_res_dest;
  logic [USER_WIDTH-1:0]              efi_res_user;
  logic                               efi_res_last;
  logic                               efi_res_valid;
  logic                               efi_res_ready;

  modport slave (
    input  req_args_data, req_args_dest, req_args_user, req_args_last, req_args_valid,
    output req_args_ready,
    output req_res_data, req_res_dest, req_res_user, req_res_last, req_res_valid,
    input  req_res_ready,
    output efi_args_data, efi_args_dest, efi_args_user, efi_args_last, efi_args_valid,
    input  efi_args_ready,
    input  efi_res_data, efi_res_dest, efi_res_user, efi_res_last, efi_res_valid,
    output efi_res_ready
  );

  modport master (
    output req_args_data, req_args_dest, req_args_user, req_args_last, req_args_valid,
    input  req_args_ready,
    input  req_res_data, req_res_dest, req_res_user, req_res_last, req_res_valid,
    output req_res_ready,
    input  efi_args_data, efi_args_dest, efi_args_user, efi_args_last, efi_args_valid,
    output efi_args_ready,
    output efi_res_data, efi_res_dest, efi_res_user, efi_res_last, efi_res_valid,
    input  efi_res_ready
  );
endinterface

// File: rtl/efi_arbiter.sv
// EFI arbiter: shares one EFI unit between N_REQUESTERS fCore requesters.
// Round-robin grant in IDLE, argument burst forwarded in ARGS, result burst
// returned to the owner in RESULTS. Define EFI_ARBITER_TIMEOUT_EN to build in
// the result watchdog (synthetic error beat after TIMEOUT_CYCLES of silence).
module efi_arbiter #(
  parameter int N_REQUESTERS   = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int DEST_WIDTH     = 8,
  parameter int USER_WIDTH     = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  efi_arbiter_if.slave            bus,
  output logic [N_REQUESTERS-1:0] grant,
  output logic                    busy,
  output logic                    timeout_error
);

  localparam int IDX_W = (N_REQUESTERS > 1) ? $clog2(N_REQUESTERS) : 1;
  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N_REQUESTERS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARGS    = 2'd1,
    RESULTS = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [N_REQUESTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]        gidx_q, gidx_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;

  logic                    scan_hit;
  logic [IDX_W-1:0]        scan_idx;
  logic [IDX_W:0]          cand;
  logic [IDX_W:0]          ptr_inc;
  logic [IDX_W-1:0]        ptr_next;

  logic [DATA_WIDTH-1:0]   sel_data;
  logic [DEST_WIDTH-1:0]   sel_dest;
  logic [USER_WIDTH-1:0]   sel_user;
  logic                    sel_last;
  logic                    sel_valid;
  logic                    sel_res_ready;

  logic                    res_hs;
  logic                    synth_done;
`ifdef EFI_ARBITER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]         wdog_q;
  logic                    synth_q;
  logic                    timeout_q;
`else
  logic                    unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // Wrap-around scan of requests starting at the priority pointer.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = ptr_q;
    cand     = '0;
    for (int unsigned i = 0; i < N_REQUESTERS; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand >= N_W) cand = cand - N_W;
      if (!scan_hit && bus.req_args_valid[cand[IDX_W-1:0]]) begin
        scan_hit = 1'b1;
        scan_idx = cand[IDX_W-1:0];
      end
    end
  end

  // Pointer value after the current owner finishes: owner + 1 mod N.
  always_comb begin
    ptr_inc  = {1'b0, gidx_q} + (IDX_W+1)'(1);
    ptr_next = (ptr_inc == N_W) ? '0 : ptr_inc[IDX_W-1:0];
  end

  // Select the granted requester's argument slice and result ready.
  always_comb begin
    sel_data      = '0;
    sel_dest      = '0;
    sel_user      = '0;
    sel_last      = 1'b0;
    sel_valid     = 1'b0;
    sel_res_ready = 1'b0;
    for (int unsigned i = 0; i < N_REQUESTERS; i++) begin
      if (gidx_q == IDX_W'(i)) begin
        sel_data      = bus.req_args_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_dest      = bus.req_args_dest[i*DEST_WIDTH +: DEST_WIDTH];
        sel_user      = bus.req_args_user[i*USER_WIDTH +: USER_WIDTH];
        sel_last      = bus.req_args_last[i];
        sel_valid     = bus.req_args_valid[i];
        sel_res_ready = bus.req_res_ready[i];
      end
    end
  end

  // Next-state and stream routing for IDLE / ARGS / RESULTS.
  always_comb begin
    state_d            = state_q;
    grant_d            = grant_q;
    gidx_d             = gidx_q;
    ptr_d              = ptr_q;
    res_hs             = 1'b0;
    synth_done         = 1'b0;
    bus.req_args_ready = '0;
    bus.req_res_data   = '0;
    bus.req_res_dest   = '0;
    bus.req_res_user   = '0;
    bus.req_res_last   = 1'b0;
    bus.req_res_valid  = '0;
    bus.efi_args_data  = '0;
    bus.efi_args_dest  = '0;
    bus.efi_args_user  = '0;
    bus.efi_args_last  = 1'b0;
    bus.efi_args_valid = 1'b0;
    bus.efi_res_ready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (scan_hit) begin
          state_d           = ARGS;
          gidx_d            = scan_idx;
          grant_d           = '0;
          grant_d[scan_idx] = 1'b1;
        end
      end
      ARGS: begin
        bus.efi_args_data          = sel_data;
        bus.efi_args_dest          = sel_dest;
        bus.efi_args_user          = sel_user;
        bus.efi_args_last          = sel_last;
        bus.efi_args_valid         = sel_valid;
        bus.req_args_ready[gidx_q] = bus.efi_args_ready;
        if (sel_valid && bus.efi_args_ready && sel_last) state_d = RESULTS;
      end
      RESULTS: begin
`ifdef EFI_ARBITER_TIMEOUT_EN
        if (synth_q) begin
          // Synthetic error beat replaces the EFI stream; EFI is not drained.
          bus.req_res_valid[gidx_q] = 1'b1;
          bus.req_res_user          = '1;
          bus.req_res_last          = 1'b1;
          synth_done                = sel_res_ready;
        end else
`endif
        begin
          bus.req_res_data          = bus.efi_res_data;
          bus.req_res_dest          = bus.efi_res_dest;
          bus.req_res_user          = bus.efi_res_user;
          bus.req_res_last          = bus.efi_res_last;
          bus.req_res_valid[gidx_q] = bus.efi_res_valid;
          bus.efi_res_ready         = sel_res_ready;
          res_hs                    = bus.efi_res_valid && sel_res_ready;
        end
        if ((res_hs && bus.efi_res_last) || synth_done) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = ptr_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbitration state, owner and priority pointer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef EFI_ARBITER_TIMEOUT_EN
  // Result watchdog: counts silent RESULTS cycles, raises the synthetic beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      wdog_q    <= '0;
      synth_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (state_q != RESULTS) begin
        wdog_q  <= '0;
        synth_q <= 1'b0;
      end else if (synth_q) begin
        if (synth_done) begin
          synth_q   <= 1'b0;
          timeout_q <= 1'b1;
        end
      end else if (res_hs) begin
        wdog_q <= '0;
      end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
        synth_q <= 1'b1;
      end else begin
        wdog_q <= wdog_q + 1'b1;
      end
    end
  end
  assign timeout_error = timeout_q;
`else
  assign timeout_error = 1'b0;
`endif

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_efi_arbiter.sv
// Directed bench for efi_arbiter: reset, single transaction, round-robin,
// result backpressure, reset mid-burst and the result watchdog.
module tb_efi_arbiter;
  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int DESTW = 8;
  localparam int UW    = 1;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] grant;
  logic         busy;
  logic         timeout_error;

  int vectors     = 0;
  int miscompares = 0;

  efi_arbiter_if #(.N_REQUESTERS(N), .DATA_WIDTH(DW), .DEST_WIDTH(DESTW),
                   .USER_WIDTH(UW)) bus ();

  efi_arbiter #(
    .N_REQUESTERS(N), .DATA_WIDTH(DW), .DEST_WIDTH(DESTW),
    .USER_WIDTH(UW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus.slave),
    .grant(grant), .busy(busy), .timeout_error(timeout_error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_args(input int idx, input logic [DW-1:0] data,
                          input logic last, input logic valid);
    bus.req_args_data[idx*DW +: DW] = data;
    bus.req_args_last[idx]          = last;
    bus.req_args_valid[idx]         = valid;
  endtask

  task automatic idle_inputs();
    bus.req_args_data  = '0;
    bus.req_args_dest  = '0;
    bus.req_args_user  = '0;
    bus.req_args_last  = '0;
    bus.req_args_valid = '0;
    bus.req_res_ready  = '1;
    bus.efi_args_ready = 1'b1;
    bus.efi_res_data   = '0;
    bus.efi_res_dest   = '0;
    bus.efi_res_user   = '0;
    bus.efi_res_last   = 1'b0;
    bus.efi_res_valid  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if ({grant, busy, timeout_error, bus.req_args_ready, bus.req_res_valid,
         bus.efi_args_valid, bus.efi_res_ready} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: grant=%b busy=%b to=%b args_rdy=%b res_vld=%b efi_av=%b efi_rr=%b, all required 0",
               grant, busy, timeout_error, bus.req_args_ready, bus.req_res_valid,
               bus.efi_args_valid, bus.efi_res_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    set_args(1, 32'h1, 1'b0, 1'b1);
    #1;
    vectors++;
    if (bus.req_args_ready !== 4'b0000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_ready: ready=%b busy=%b required 0000/0", bus.req_args_ready, busy);
    end
    tick();
    vectors++;
    if (grant !== 4'b0010 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_grant: grant=%b busy=%b required 0010/1", grant, busy);
    end
    vectors++;
    if (bus.efi_args_valid !== 1'b1 || bus.efi_args_data !== 32'h1 ||
        bus.req_args_ready !== 4'b0010 || bus.efi_res_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL args_beat1: v=%b d=%h rdy=%b efi_rr=%b required 1/1/0010/0",
               bus.efi_args_valid, bus.efi_args_data, bus.req_args_ready, bus.efi_res_ready);
    end
    tick();
    set_args(1, 32'h2, 1'b0, 1'b1);
    #1;
    vectors++;
    if (bus.efi_args_data !== 32'h2 || bus.efi_args_last !== 1'b0) begin
      miscompares++;
      $display("FAIL args_beat2: d=%h last=%b required 2/0", bus.efi_args_data, bus.efi_args_last);
    end
    tick();
    set_args(1, 32'h3, 1'b1, 1'b1);
    #1;
    vectors++;
    if (bus.efi_args_data !== 32'h3 || bus.efi_args_last !== 1'b1) begin
      miscompares++;
      $display("FAIL args_beat3: d=%h last=%b required 3/1", bus.efi_args_data, bus.efi_args_last);
    end
    tick();
    set_args(1, 32'h0, 1'b0, 1'b0);
    bus.efi_res_valid = 1'b1;
    bus.efi_res_data  = 32'hA0;
    bus.efi_res_last  = 1'b0;
    #1;
    vectors++;
    if (bus.efi_args_valid !== 1'b0 || bus.req_res_valid !== 4'b0010 ||
        bus.req_res_data !== 32'hA0 || bus.efi_res_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL res_beat1: efi_av=%b res_v=%b d=%h efi_rr=%b required 0/0010/a0/1",
               bus.efi_args_valid, bus.req_res_valid, bus.req_res_data, bus.efi_res_ready);
    end
    tick();
    bus.efi_res_data = 32'hA1;
    bus.efi_res_last = 1'b1;
    #1;
    vectors++;
    if (bus.req_res_data !== 32'hA1 || bus.req_res_last !== 1'b1) begin
      miscompares++;
      $display("FAIL res_beat2: d=%h last=%b required a1/1", bus.req_res_data, bus.req_res_last);
    end
    tick();
    bus.efi_res_valid = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_done: busy=%b grant=%b required 0/0000", busy, grant);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    idle_inputs();
    do_reset();
    for (int i = 0; i < N; i++) set_args(i, 32'h10 + i, 1'b1, 1'b1);
    bus.efi_res_valid = 1'b1;
    bus.efi_res_last  = 1'b1;
    bus.efi_res_data  = 32'h55;
    for (int t = 0; t < 8; t++) begin
      exp = 4'b0001 << (t % 4);
      tick();
      vectors++;
      if (grant !== exp || bus.efi_args_data !== 32'h10 + (t % 4)) begin
        miscompares++;
        $display("FAIL rr_grant[%0d]: grant=%b d=%h required %b/%h",
                 t, grant, bus.efi_args_data, exp, 32'h10 + (t % 4));
      end
      tick();
      vectors++;
      if (bus.req_res_valid !== exp) begin
        miscompares++;
        $display("FAIL rr_res_valid[%0d]: %b required %b", t, bus.req_res_valid, exp);
      end
      tick();
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rr_idle_gap[%0d]: busy=%b required 0", t, busy);
      end
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] rx [4];
    int k;
    int n_rx;
    k    = 0;
    n_rx = 0;
    set_args(2, 32'h20, 1'b1, 1'b1);
    tick();
    vectors++;
    if (grant !== 4'b0100) begin
      miscompares++;
      $display("FAIL bp_grant: grant=%b required 0100", grant);
    end
    tick();
    set_args(2, 32'h0, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 20 && k < 3; cyc++) begin
      bus.efi_res_data  = 32'hB0 + k;
      bus.efi_res_last  = (k == 2);
      bus.efi_res_valid = 1'b1;
      bus.req_res_ready = (cyc >= 1 && cyc <= 5) ? 4'b1011 : 4'b1111;
      #1;
      if (cyc >= 1 && cyc <= 5) begin
        vectors++;
        if (bus.efi_res_ready !== 1'b0 || bus.req_res_valid !== 4'b0100) begin
          miscompares++;
          $display("FAIL bp_stall[%0d]: efi_rr=%b res_v=%b required 0/0100",
                   cyc, bus.efi_res_ready, bus.req_res_valid);
        end
      end
      if (bus.req_res_valid[2] && bus.req_res_ready[2]) begin
        if (n_rx < 4) rx[n_rx] = bus.req_res_data;
        n_rx++;
      end
      if (bus.efi_res_valid && bus.efi_res_ready) k++;
      tick();
    end
    bus.efi_res_valid = 1'b0;
    bus.req_res_ready = '1;
    vectors++;
    if (n_rx !== 3) begin
      miscompares++;
      $display("FAIL bp_count: received %0d beats required 3", n_rx);
    end else begin
      for (int j = 0; j < 3; j++) begin
        vectors++;
        if (rx[j] !== 32'hB0 + j) begin
          miscompares++;
          $display("FAIL bp_beat[%0d]: %h required %h", j, rx[j], 32'hB0 + j);
        end
      end
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_done: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    set_args(3, 32'h31, 1'b0, 1'b1);
    tick();
    vectors++;
    if (grant !== 4'b1000) begin
      miscompares++;
      $display("FAIL rm_grant3: grant=%b required 1000", grant);
    end
    tick();
    set_args(3, 32'h32, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.efi_args_data !== 32'h32 || bus.efi_args_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rm_beat2: d=%h v=%b required 32/1", bus.efi_args_data, bus.efi_args_valid);
    end
    tick();
    vectors++;
    if ({grant, busy, timeout_error, bus.req_args_ready, bus.req_res_valid,
         bus.efi_args_valid, bus.efi_res_ready} !== '0) begin
      miscompares++;
      $display("FAIL rm_outputs: grant=%b busy=%b args_rdy=%b res_v=%b efi_av=%b efi_rr=%b, all required 0",
               grant, busy, bus.req_args_ready, bus.req_res_valid, bus.efi_args_valid,
               bus.efi_res_ready);
    end
    reset = 1'b0;
    set_args(0, 32'h01, 1'b1, 1'b1);
    tick();
    vectors++;
    if (grant !== 4'b0001) begin
      miscompares++;
      $display("FAIL rm_ptr_zero: grant=%b required 0001", grant);
    end
    set_args(3, 32'h0, 1'b0, 1'b0);
    tick();
    set_args(0, 32'h0, 1'b0, 1'b0);
    bus.efi_res_valid = 1'b1;
    bus.efi_res_last  = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_timeout();
    idle_inputs();
    do_reset();
    set_args(0, 32'h77, 1'b1, 1'b1);
    tick();
    tick();
    set_args(0, 32'h0, 1'b0, 1'b0);
    bus.req_res_ready = 4'b1110;
`ifdef EFI_ARBITER_TIMEOUT_EN
    for (int c = 0; c < 16; c++) begin
      if (c == 15) begin
        vectors++;
        if (bus.req_res_valid !== 4'b0000) begin
          miscompares++;
          $display("FAIL to_early: res_v=%b required 0000 at cycle 15", bus.req_res_valid);
        end
      end
      tick();
    end
    vectors++;
    if (bus.req_res_valid !== 4'b0001 || bus.req_res_data !== 32'h0 ||
        bus.req_res_dest !== 8'h0 || bus.req_res_user !== 1'b1 ||
        bus.req_res_last !== 1'b1 || bus.efi_res_ready !== 1'b0 || timeout_error !== 1'b0) begin
      miscompares++;
      $display("FAIL to_beat: v=%b d=%h dest=%h u=%b last=%b efi_rr=%b to=%b required 0001/0/0/1/1/0/0",
               bus.req_res_valid, bus.req_res_data, bus.req_res_dest, bus.req_res_user,
               bus.req_res_last, bus.efi_res_ready, timeout_error);
    end
    tick();
    vectors++;
    if (bus.req_res_valid !== 4'b0001) begin
      miscompares++;
      $display("FAIL to_hold: res_v=%b required 0001", bus.req_res_valid);
    end
    bus.req_res_ready = '1;
    tick();
    vectors++;
    if (timeout_error !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL to_pulse: to=%b busy=%b required 1/0", timeout_error, busy);
    end
    tick();
    vectors++;
    if (timeout_error !== 1'b0) begin
      miscompares++;
      $display("FAIL to_pulse_end: to=%b required 0", timeout_error);
    end
`else
    repeat (40) tick();
    vectors++;
    if (busy !== 1'b1 || timeout_error !== 1'b0 || bus.req_res_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL no_to_wait: busy=%b to=%b res_v=%b required 1/0/0000",
               busy, timeout_error, bus.req_res_valid);
    end
    bus.efi_res_valid = 1'b1;
    bus.efi_res_last  = 1'b1;
    bus.req_res_ready = '1;
    tick();
    bus.efi_res_valid = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL no_to_recover: busy=%b required 0", busy);
    end
`endif
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: bench still running at 200000, required completion");
    $fatal(1);
  end

endmodule

// File: doc/efi_arbiter.md
EFI_ARBITER -- requirements
Module: efi_arbiter

Interface
REQ-001 SHALL have parameter N_REQUESTERS, default 4, number of fCore EFI requesters sharing one EFI unit (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, EFI data beat width.
REQ-003 SHALL have parameter DEST_WIDTH, default 8, EFI dest field width.
REQ-004 SHALL have parameter USER_WIDTH, default 1, EFI user field width.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024, result watchdog limit.
REQ-006 SHALL have port clock  in  1  single clock for all logic.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port req_args_data/dest/user  in  N_REQUESTERS x DATA/DEST/USER_WIDTH  flattened argument beats, requester i at slice i.
REQ-009 SHALL have ports req_args_last, req_args_valid  in  N_REQUESTERS  per-requester argument tlast/tvalid.
REQ-010 SHALL have port req_args_ready  out  N_REQUESTERS  per-requester argument tready.
REQ-011 SHALL have ports req_res_data/dest/user/last  out  DATA/DEST/USER_WIDTH/1  result beat broadcast to all requesters.
REQ-012 SHALL have port req_res_valid  out  N_REQUESTERS  result tvalid, only granted bit may be high.
REQ-013 SHALL have port req_res_ready  in  N_REQUESTERS  per-requester result tready.
REQ-014 SHALL have ports efi_args_data/dest/user/last/valid  out, efi_args_ready  in  -- stream to EFI unit.
REQ-015 SHALL have ports efi_res_data/dest/user/last/valid  in, efi_res_ready  out  -- stream from EFI unit.
REQ-016 SHALL have ports grant  out  N_REQUESTERS  one-hot owner; busy  out  1  high when not IDLE; timeout_error  out  1  one-cycle pulse.

Function
REQ-017 SHALL implement states IDLE, ARGS, RESULTS; grant and state registered.
REQ-018 IDLE: SHALL scan req_args_valid starting at priority pointer, wrap-around; first asserted index granted, ARGS entered next cycle; no req_args_ready asserted in IDLE.
REQ-019 Simultaneous requests SHALL resolve round-robin: pointer after a completed transaction = (granted+1) mod N_REQUESTERS.
REQ-020 ARGS: efi_args_* SHALL combinationally mirror granted requester slice; req_args_ready[granted]=efi_args_ready; all other ready bits 0.
REQ-021 ARGS: handshake with last=1 SHALL move to RESULTS next cycle; efi_res_ready SHALL be 0 in ARGS and IDLE.
REQ-022 RESULTS: req_res_valid[granted]=efi_res_valid, efi_res_ready=req_res_ready[granted], beat fields passed unchanged; efi_args_valid=0.
REQ-023 RESULTS: handshake with last=1 SHALL return to IDLE next cycle, clear grant, advance pointer; a new grant is possible no earlier than the following cycle (one idle cycle minimum between transactions).
REQ-024 Requesters dropping valid while not granted SHALL lose no priority; valid dropped mid-ARGS SHALL stall (no timeout on argument phase).
REQ-025 Zero-beat bursts not supported; single-beat burst (last on first beat) SHALL be valid.

Reset
REQ-026 On reset: state IDLE, grant 0, pointer 0, busy 0, timeout_error 0, all valid/ready outputs 0, watchdog 0; any in-flight transaction abandoned, no beat emitted.
REQ-027 Reset asserted mid-burst SHALL take effect at next clock edge regardless of handshakes that cycle.

Configuration
REQ-028 Macro EFI_ARBITER_TIMEOUT_EN SHALL compile in the result watchdog.
REQ-029 With macro: counter clears on entering RESULTS and on each result handshake, increments otherwise; reaching TIMEOUT_CYCLES SHALL emit one synthetic beat to granted requester (data 0, dest 0, user all-ones, last 1), held until req_res_ready, pulse timeout_error, then IDLE with pointer advance; efi_res_ready 0 during synthetic beat.
REQ-030 Without macro: no counter logic, timeout_error tied 0, RESULTS waits indefinitely.

Verification
REQ-031 Single requester 1, 3 argument beats 0x1,0x2,0x3(last), EFI returns 2 beats -> grant=4'b0010, EFI sees 3 beats in order, requester 1 receives 2 beats, back to IDLE, busy 0.
REQ-032 All 4 requesters valid at once, repeated 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-033 Requester 2 stalls req_res_ready for 5 cycles mid-result -> efi_res_ready 0 those cycles, no beat lost or duplicated.
REQ-034 Reset asserted during ARGS beat 2 of requester 3 -> next cycle all outputs 0, pointer 0; subsequent request from requester 0 granted first.
REQ-035 With EFI_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=16, EFI never responds -> after 16 cycles in RESULTS granted requester gets beat user=1,last=1,data=0, timeout_error pulses once; without macro busy stays 1.
